// File: rtl/pwm_rgb_capture_if.sv
// pwm_rgb_capture_if: control, PWM input and result bundle for the RGB PWM duty capture block
// Signals: tick (sample enable), enable (run level), pwm_in[2:0] (R,G,B lines),
//          duty_r/g/b (last window result), sat[2:0] (line high for a whole window),
//          valid (one-cycle result strobe), busy (measuring); stable only with PWM_CAPTURE_STABLE_EN.
// Modports: master drives tick/enable/pwm_in; slave (the capture block) drives the results.
interface pwm_rgb_capture_if #(parameter int WINDOW_LOG2 = 8);
   logic                   tick;
   logic                   enable;
   logic [2:0]             pwm_in;
   logic [WINDOW_LOG2-1:0] duty_r;
   logic [WINDOW_LOG2-1:0] duty_g;
   logic [WINDOW_LOG2-1:0] duty_b;
   logic [2:0]             sat;
   logic                   valid;
   logic                   busy;
`ifdef PWM_CAPTURE_STABLE_EN
   logic                   stable;
   modport master (output tick, enable, pwm_in, input duty_r, duty_g, duty_b, sat, valid, busy, stable);
   modport slave  (input tick, enable, pwm_in, output duty_r, duty_g, duty_b, sat, valid, busy, stable);
`else
   modport master (output tick, enable, pwm_in, input duty_r, duty_g, duty_b, sat, valid, busy);
   modport slave  (input tick, enable, pwm_in, output duty_r, duty_g, duty_b, sat, valid, busy);
`endif
endinterface

// File: rtl/pwm_rgb_capture.sv
// pwm_rgb_capture: measures the duty of three PWM lines over 2^WINDOW_LOG2-tick windows
// Ports: clk, rst (async, active high), bus (pwm_rgb_capture_if.slave: tick, enable, pwm_in in;
//        duty_r/g/b, sat, valid, busy out). Optional macro PWM_CAPTURE_STABLE_EN adds bus.stable,
//        which flags a window whose result equals the previous window's.
module pwm_rgb_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int WINDOW_LOG2 = 8
) (
   input logic             clk,
   input logic             rst,
   pwm_rgb_capture_if.slave bus
);
   localparam int W = WINDOW_LOG2;
   typedef enum logic {IDLE, MEASURE} state_t;
   state_t                     r_state, w_next;
   logic [SYNC_STAGES-1:0][2:0] r_sync;
   logic [W-1:0]               r_win;
   logic [2:0][W:0]            r_hi, w_hi;
   logic [2:0][W-1:0]          w_duty;
   logic [2:0]                 w_s, w_sat;
   logic                       w_meas, w_tick, w_term;
   assign w_s = r_sync[SYNC_STAGES-1];
   always_ff @(posedge clk or posedge rst)
      if (rst) r_sync <= '0;
      else r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   // enable alone decides: IDLE enters MEASURE on it, MEASURE falls back to IDLE without it
   always_comb w_next = bus.enable ? MEASURE : IDLE;
   always_comb bus.busy = (r_state == MEASURE);
   // a cycle with enable low in MEASURE is the abort cycle and counts nothing
   assign w_meas = (r_state == MEASURE) && bus.enable;
   assign w_tick = w_meas && bus.tick;
   assign w_term = w_tick && (r_win == '1);
   // results use the counts including the current sample so the terminal tick is part of the window;
   // a count can reach at most 2^W, so its top bit alone marks saturation
   always_comb
      for (int c = 0; c < 3; c++) begin
         w_hi[c]   = r_hi[c] + (W+1)'(w_tick && w_s[c]);
         w_duty[c] = w_hi[c][W] ? '1 : w_hi[c][W-1:0];
         w_sat[c]  = w_hi[c][W];
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_win <= '0;
         r_hi  <= '0;
      end else if (!w_meas || w_term) begin
         r_win <= '0;
         r_hi  <= '0;
      end else if (w_tick) begin
         r_win <= r_win + 1'b1;
         r_hi  <= w_hi;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.duty_r <= '0;
         bus.duty_g <= '0;
         bus.duty_b <= '0;
         bus.sat    <= '0;
         bus.valid  <= 1'b0;
      end else begin
         bus.valid <= w_term;
         if (w_term) begin
            bus.duty_r <= w_duty[2];
            bus.duty_g <= w_duty[1];
            bus.duty_b <= w_duty[0];
            bus.sat    <= w_sat;
         end
      end
`ifdef PWM_CAPTURE_STABLE_EN
   logic [3*W+2:0] r_hist, w_res;
   logic           r_hist_v;
   assign w_res = {w_duty[2], w_duty[1], w_duty[0], w_sat};
   // history is forgotten whenever the block idles, so the first window after it never reads stable
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_hist     <= '0;
         r_hist_v   <= 1'b0;
         bus.stable <= 1'b0;
      end else if (r_state == IDLE) r_hist_v <= 1'b0;
      else if (w_term) begin
         bus.stable <= r_hist_v && (w_res == r_hist);
         r_hist     <= w_res;
         r_hist_v   <= 1'b1;
      end
`endif
endmodule

// File: tb/tb_pwm_rgb_capture.sv
// tb_pwm_rgb_capture: directed and randomized checks of the PWM duty capture against a window model
module tb_pwm_rgb_capture;
   logic clk = 1'b0;
   logic rst;
   pwm_rgb_capture_if bus();
   pwm_rgb_capture dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int errors = 0, checks = 0;
   int duty [3];
   int spacing = 1, div = 0, phase = 0, skip = 0, m_ticks = 0;
   logic m_state = 1'b0;
`ifdef PWM_CAPTURE_STABLE_EN
   logic [26:0] prev_res;
   logic prev_known = 1'b0, first_win = 1'b1;
`endif
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [2:0] gen(input int ph);
      logic [2:0] g;
      for (int c = 0; c < 3; c++) g[c] = (duty[c] >= 256) || ((ph & 255) < duty[c]);
      return g;
   endfunction
   function automatic logic [7:0] exp_duty(input int d);
      return (d >= 256) ? 8'hFF : d[7:0];
   endfunction
   // one clock: advance the window model across the edge, compare, then drive the next inputs
   task automatic step();
      logic tk, en, ev;
      logic [26:0] res;
      tk = bus.tick;
      en = bus.enable;
      @(posedge clk);
      #1;
      if (rst) begin
         m_state = 1'b0;
         m_ticks = 0;
         ev = 1'b0;
      end else begin
         ev = m_state && en && tk && (m_ticks == 255);
         m_ticks = (m_state && en) ? (ev ? 0 : m_ticks + int'(tk)) : 0;
         m_state = en;
      end
      chk("valid", bus.valid, ev);
      chk("busy", bus.busy, m_state);
      res = {exp_duty(duty[2]), exp_duty(duty[1]), exp_duty(duty[0]),
             duty[2] >= 256, duty[1] >= 256, duty[0] >= 256};
      if (ev) begin
         if (skip > 0) begin
            skip--;
`ifdef PWM_CAPTURE_STABLE_EN
            prev_known = 1'b0;
            first_win = 1'b0;
`endif
         end else begin
            chk("duty_r", bus.duty_r, res[26:19]);
            chk("duty_g", bus.duty_g, res[18:11]);
            chk("duty_b", bus.duty_b, res[10:3]);
            chk("sat", bus.sat, res[2:0]);
`ifdef PWM_CAPTURE_STABLE_EN
            if (prev_known || first_win) chk("stable", bus.stable, prev_known && (prev_res == res));
            prev_known = 1'b1;
            prev_res = res;
            first_win = 1'b0;
`endif
         end
      end
`ifdef PWM_CAPTURE_STABLE_EN
      if (!m_state) begin
         prev_known = 1'b0;
         first_win = 1'b1;
      end
`endif
      if (div == 0) begin
         bus.tick = 1'b1;
         bus.pwm_in = gen(phase);
         phase++;
      end else bus.tick = 1'b0;
      div = (div + 1) % spacing;
   endtask
   task automatic run_windows(input int n);
      int seen = 0;
      int budget = n * 256 * spacing + 600;
      for (int i = 0; i < budget && seen < n; i++) begin
         step();
         if (bus.valid === 1'b1) seen++;
      end
      chk("window_count", seen, n);
   endtask
   task automatic set_duty(input int r, input int g, input int b);
      duty[2] = r;
      duty[1] = g;
      duty[0] = b;
   endtask
   task automatic run_to_tick(input int t);
      for (int i = 0; i < 2000 && m_ticks < t; i++) step();
      chk("reach_tick", m_ticks, t);
   endtask
   initial begin
      rst = 1'b1;
      bus.tick = 1'b0;
      bus.enable = 1'b0;
      bus.pwm_in = 3'b000;
      set_duty(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_duty_r", bus.duty_r, 0);
      chk("rst_duty_g", bus.duty_g, 0);
      chk("rst_duty_b", bus.duty_b, 0);
      chk("rst_sat", bus.sat, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b0;
      // loopback of a running generator, tick every clock
      set_duty(8'h40, 8'h80, 8'h00);
      skip = 1;
      bus.enable = 1'b1;
      run_windows(3);
      // saturated red, nearly full green, dead blue
      set_duty(256, 8'hFF, 0);
      skip = 1;
      run_windows(2);
      // slow tick, generator phase offset from the window start, already steady before enable
      bus.enable = 1'b0;
      set_duty(8'h33, 8'h33, 8'h33);
      spacing = 4;
      div = 0;
      phase = 100;
      repeat (40) step();
      skip = 0;
      bus.enable = 1'b1;
      run_windows(1);
      // abort mid-window, old results held, fresh 256-tick window after re-entry
      spacing = 1;
      div = 0;
      set_duty(8'h40, 8'h80, 8'h10);
      skip = 1;
      run_windows(2);
      run_to_tick(128);
      bus.enable = 1'b0;
      repeat (10) step();
      chk("hold_r", bus.duty_r, 8'h40);
      chk("hold_g", bus.duty_g, 8'h80);
      chk("hold_b", bus.duty_b, 8'h10);
      bus.enable = 1'b1;
      skip = 0;
      run_windows(1);
      // asynchronous reset in the middle of a window
      set_duty(8'h80, 8'h80, 8'h80);
      skip = 1;
      run_windows(1);
      run_to_tick(100);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_duty_r", bus.duty_r, 0);
      chk("arst_duty_g", bus.duty_g, 0);
      chk("arst_duty_b", bus.duty_b, 0);
      chk("arst_sat", bus.sat, 0);
      chk("arst_valid", bus.valid, 0);
      chk("arst_busy", bus.busy, 0);
      m_state = 1'b0;
      m_ticks = 0;
      repeat (2) step();
      rst = 1'b0;
      skip = 1;
      run_windows(2);
      // randomized duties and tick spacing
      for (int k = 0; k < 5; k++) begin
         set_duty(int'($urandom_range(0, 256)), int'($urandom_range(0, 256)), int'($urandom_range(0, 256)));
         spacing = int'($urandom_range(1, 4));
         div = 0;
         skip = 1;
         run_windows(2);
      end
`ifdef PWM_CAPTURE_STABLE_EN
      // constant duties after an idle spell: first window not stable, second stable
      bus.enable = 1'b0;
      set_duty(8'h40, 8'h80, 8'h20);
      repeat (20) step();
      bus.enable = 1'b1;
      skip = 0;
      run_windows(2);
      set_duty(8'h40, 8'h81, 8'h20);
      skip = 1;
      run_windows(3);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
